// File: rtl/iter_mul_if.sv
// Request/response bundle between the EX stage and the iterative multiplier.
// The requester holds start_i high until it has consumed the result.
interface iter_mul_if #(
  parameter int XLEN = 64
);
  logic            start_i;
  logic            annul_i;
  logic            signed1_i;
  logic            signed2_i;
  logic            mul_32_i;
  logic            res_hi_i;
  logic [XLEN-1:0] opdata1_i;
  logic [XLEN-1:0] opdata2_i;
  logic [XLEN-1:0] mul_res_o;
  logic            ready_o;

  modport master (
    output start_i, annul_i, signed1_i, signed2_i, mul_32_i, res_hi_i,
           opdata1_i, opdata2_i,
    input  mul_res_o, ready_o
  );

  modport slave (
    input  start_i, annul_i, signed1_i, signed2_i, mul_32_i, res_hi_i,
           opdata1_i, opdata2_i,
    output mul_res_o, ready_o
  );
endinterface

// File: rtl/iter_mul.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW.
// Multiplies operand magnitudes one multiplier bit per cycle into a
// double-width accumulator, applies the sign in a single fix-up cycle, and
// holds the selected half until the requester drops start.
module iter_mul #(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  iter_mul_if.slave   bus
);

  localparam int PW   = 2 * XLEN;
  localparam int HALF = XLEN / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r,  state_nx_s;
  logic [PW-1:0]   acc_r,    acc_nx_s;
  logic [PW-1:0]   mcand_r,  mcand_nx_s;
  logic [XLEN-1:0] mplier_r, mplier_nx_s;
  logic [6:0]      cnt_r,    cnt_nx_s;
  logic            sign_r,   sign_nx_s;
  logic            mul32_r,  mul32_nx_s;
  logic            res_hi_r, res_hi_nx_s;
  logic            ready_r,  ready_nx_s;
  logic [XLEN-1:0] res_r,    res_nx_s;

  logic [XLEN-1:0] mag1_s;
  logic [XLEN-1:0] mag2_s;
  logic            sign_in_s;
  logic [6:0]      last_cnt_s;
  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] res_sel_s;

  // Absolute value of a two's complement operand when it is flagged signed.
  // The most negative value maps onto itself, read as unsigned 2^(XLEN-1).
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            s);
    if (s && v[XLEN-1]) begin
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Operand magnitudes and product sign from the live request inputs.
  always_comb begin
    mag1_s    = {XLEN{1'b0}};
    mag2_s    = {XLEN{1'b0}};
    sign_in_s = 1'b0;
    if (bus.mul_32_i) begin
      mag1_s    = {{HALF{1'b0}}, bus.opdata1_i[HALF-1:0]};
      mag2_s    = {{HALF{1'b0}}, bus.opdata2_i[HALF-1:0]};
      sign_in_s = 1'b0;
    end else begin
      mag1_s    = magnitude(bus.opdata1_i, bus.signed1_i);
      mag2_s    = magnitude(bus.opdata2_i, bus.signed2_i);
      sign_in_s = (bus.signed1_i & bus.opdata1_i[XLEN-1]) ^
                  (bus.signed2_i & bus.opdata2_i[XLEN-1]);
    end
  end

  // Sign-corrected product and the half of it the instruction asked for.
  always_comb begin
    prod_s     = {PW{1'b0}};
    res_sel_s  = {XLEN{1'b0}};
    last_cnt_s = mul32_r ? 7'd31 : 7'd63;
    if (sign_r) begin
      prod_s = ~acc_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      prod_s = acc_r;
    end
    if (mul32_r) begin
      res_sel_s = {{HALF{prod_s[HALF-1]}}, prod_s[HALF-1:0]};
    end else if (res_hi_r) begin
      res_sel_s = prod_s[PW-1:XLEN];
    end else begin
      res_sel_s = prod_s[XLEN-1:0];
    end
  end

  // Next-state and next-datapath values for the sequencing FSM.
  always_comb begin
    state_nx_s  = state_r;
    acc_nx_s    = acc_r;
    mcand_nx_s  = mcand_r;
    mplier_nx_s = mplier_r;
    cnt_nx_s    = cnt_r;
    sign_nx_s   = sign_r;
    mul32_nx_s  = mul32_r;
    res_hi_nx_s = res_hi_r;
    ready_nx_s  = ready_r;
    res_nx_s    = res_r;
    case (state_r)
      ST_IDLE: begin
        ready_nx_s = 1'b0;
        res_nx_s   = {XLEN{1'b0}};
        if (bus.start_i && !bus.annul_i) begin
          mcand_nx_s  = {{XLEN{1'b0}}, mag1_s};
          mplier_nx_s = mag2_s;
          sign_nx_s   = sign_in_s;
          mul32_nx_s  = bus.mul_32_i;
          res_hi_nx_s = bus.res_hi_i;
          acc_nx_s    = {PW{1'b0}};
          cnt_nx_s    = 7'd0;
          if ((mag1_s == {XLEN{1'b0}}) || (mag2_s == {XLEN{1'b0}})) begin
            // A zero operand makes the product zero: skip the iterations.
            state_nx_s = ST_DONE;
            ready_nx_s = 1'b1;
            res_nx_s   = {XLEN{1'b0}};
          end else begin
            state_nx_s = ST_BUSY;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.annul_i) begin
          state_nx_s = ST_IDLE;
          ready_nx_s = 1'b0;
          res_nx_s   = {XLEN{1'b0}};
        end else begin
          if (mplier_r[0]) begin
            acc_nx_s = acc_r + mcand_r;
          end else begin
            acc_nx_s = acc_r;
          end
          mcand_nx_s  = {mcand_r[PW-2:0], 1'b0};
          mplier_nx_s = {1'b0, mplier_r[XLEN-1:1]};
          cnt_nx_s    = cnt_r + 7'd1;
          if (cnt_r == last_cnt_s) begin
            state_nx_s = ST_FIX;
          end else begin
            state_nx_s = ST_BUSY;
          end
        end
      end
      ST_FIX: begin
        if (bus.annul_i) begin
          state_nx_s = ST_IDLE;
          ready_nx_s = 1'b0;
          res_nx_s   = {XLEN{1'b0}};
        end else begin
          state_nx_s = ST_DONE;
          ready_nx_s = 1'b1;
          res_nx_s   = res_sel_s;
        end
      end
      ST_DONE: begin
        // Flush has no effect here: the result is already committed.
        if (!bus.start_i) begin
          state_nx_s = ST_IDLE;
          ready_nx_s = 1'b0;
          res_nx_s   = {XLEN{1'b0}};
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        ready_nx_s = 1'b0;
        res_nx_s   = {XLEN{1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and registered output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= {PW{1'b0}};
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {XLEN{1'b0}};
      cnt_r    <= 7'd0;
      sign_r   <= 1'b0;
      mul32_r  <= 1'b0;
      res_hi_r <= 1'b0;
      ready_r  <= 1'b0;
      res_r    <= {XLEN{1'b0}};
    end else begin
      acc_r    <= acc_nx_s;
      mcand_r  <= mcand_nx_s;
      mplier_r <= mplier_nx_s;
      cnt_r    <= cnt_nx_s;
      sign_r   <= sign_nx_s;
      mul32_r  <= mul32_nx_s;
      res_hi_r <= res_hi_nx_s;
      ready_r  <= ready_nx_s;
      res_r    <= res_nx_s;
    end
  end

  assign bus.ready_o   = ready_r;
  assign bus.mul_res_o = res_r;

endmodule

// File: tb/tb_iter_mul.sv
// Directed bench for iter_mul: latency, signed/unsigned halves, MULW,
// zero fast path, annul, reset mid-operation and back-to-back requests.
module tb_iter_mul;

  logic clk = 1'b0;
  logic rst;

  // Free-running clock.
  always #5 clk = ~clk;

  iter_mul_if bus ();

  iter_mul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic issue(input logic s1, input logic s2, input logic m32,
                       input logic hi, input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    bus.signed1_i = s1;
    bus.signed2_i = s2;
    bus.mul_32_i  = m32;
    bus.res_hi_i  = hi;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i   = 1'b1;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.ready_o && edges < 200);
  endtask

  task automatic release_req();
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.annul_i   = 1'b0;
    bus.signed1_i = 1'b0;
    bus.signed2_i = 1'b0;
    bus.mul_32_i  = 1'b0;
    bus.res_hi_i  = 1'b0;
    bus.opdata1_i = 64'd0;
    bus.opdata2_i = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready_o);
    else n_pass++;
    n_checks++;
    if (bus.mul_res_o !== 64'd0) $display("FAIL reset_res got %h want 0", bus.mul_res_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_mul();
    int e;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 64'd7, 64'd6);
    wait_ready(e);
    n_checks++;
    if (e !== 66) $display("FAIL basic_latency got %0d want 66", e);
    else n_pass++;
    n_checks++;
    if (bus.mul_res_o !== 64'h2A) $display("FAIL basic_res got %h want 2a", bus.mul_res_o);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b1 || bus.mul_res_o !== 64'h2A)
      $display("FAIL basic_hold got %b/%h want 1/2a", bus.ready_o, bus.mul_res_o);
    else n_pass++;
    release_req();
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.mul_res_o !== 64'd0)
      $display("FAIL basic_drop got %b/%h want 0/0", bus.ready_o, bus.mul_res_o);
    else n_pass++;
  endtask

  task automatic test_signed_high();
    int e;
    issue(1'b1, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_ready(e);
    n_checks++;
    if (e !== 66 || bus.mul_res_o !== 64'd0)
      $display("FAIL mulh_m1m1 got %0d/%h want 66/0", e, bus.mul_res_o);
    else n_pass++;
    release_req();
    issue(1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_ready(e);
    n_checks++;
    if (bus.mul_res_o !== 64'd0)
      $display("FAIL mulh_min_m1 got %h want 0", bus.mul_res_o);
    else n_pass++;
    release_req();
    issue(1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_ready(e);
    n_checks++;
    if (bus.mul_res_o !== 64'h8000_0000_0000_0000)
      $display("FAIL mul_min_m1_lo got %h want 8000000000000000", bus.mul_res_o);
    else n_pass++;
    release_req();
  endtask

  task automatic test_unsigned_mixed();
    int e;
    issue(1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_ready(e);
    n_checks++;
    if (bus.mul_res_o !== 64'hFFFF_FFFF_FFFF_FFFE)
      $display("FAIL mulhu_max got %h want fffffffffffffffe", bus.mul_res_o);
    else n_pass++;
    release_req();
    issue(1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    wait_ready(e);
    n_checks++;
    if (bus.mul_res_o !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL mulhsu_m1_2 got %h want ffffffffffffffff", bus.mul_res_o);
    else n_pass++;
    release_req();
  endtask

  task automatic test_mulw();
    int e;
    issue(1'b1, 1'b1, 1'b1, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2);
    wait_ready(e);
    n_checks++;
    if (e !== 34) $display("FAIL mulw_latency got %0d want 34", e);
    else n_pass++;
    n_checks++;
    if (bus.mul_res_o !== 64'hFFFF_FFFF_FFFF_FFFE)
      $display("FAIL mulw_res got %h want fffffffffffffffe", bus.mul_res_o);
    else n_pass++;
    release_req();
  endtask

  task automatic test_zero();
    int e;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 64'h1234, 64'd0);
    wait_ready(e);
    n_checks++;
    if (e !== 1 || bus.mul_res_o !== 64'd0)
      $display("FAIL zero_op2 got %0d/%h want 1/0", e, bus.mul_res_o);
    else n_pass++;
    release_req();
    // Upper half nonzero but masked away by MULW.
    issue(1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 64'd5);
    wait_ready(e);
    n_checks++;
    if (e !== 1 || bus.mul_res_o !== 64'd0)
      $display("FAIL zero_mulw_mask got %0d/%h want 1/0", e, bus.mul_res_o);
    else n_pass++;
    release_req();
  endtask

  task automatic test_annul();
    int e;
    logic seen;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd100);
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    // start and annul together while IDLE must not be accepted.
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL annul_ready got %b want 0", seen);
    else n_pass++;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 64'd3, 64'd5);
    wait_ready(e);
    n_checks++;
    if (e !== 66 || bus.mul_res_o !== 64'd15)
      $display("FAIL annul_next got %0d/%h want 66/f", e, bus.mul_res_o);
    else n_pass++;
    release_req();
  endtask

  task automatic test_reset_mid();
    int e;
    logic seen;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 64'd123, 64'd456);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.mul_res_o !== 64'd0)
      $display("FAIL rst_mid got %b/%h want 0/0", bus.ready_o, bus.mul_res_o);
    else n_pass++;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL rst_mid_quiet got %b want 0", seen);
    else n_pass++;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 64'd2, 64'd3);
    wait_ready(e);
    n_checks++;
    if (e !== 66 || bus.mul_res_o !== 64'd6)
      $display("FAIL rst_mid_next got %0d/%h want 66/6", e, bus.mul_res_o);
    else n_pass++;
    release_req();
  endtask

  task automatic test_back_to_back();
    int e;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 64'd9, 64'd11);
    wait_ready(e);
    n_checks++;
    if (bus.mul_res_o !== 64'd99) $display("FAIL b2b_first got %h want 63", bus.mul_res_o);
    else n_pass++;
    @(negedge clk);
    bus.start_i = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0003);
    wait_ready(e);
    n_checks++;
    if (e !== 66 || bus.mul_res_o !== 64'd1)
      $display("FAIL b2b_second got %0d/%h want 66/1", e, bus.mul_res_o);
    else n_pass++;
    release_req();
  endtask

  task automatic test_operand_change();
    int e;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 64'd5, 64'd1000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.opdata1_i = 64'hDEAD_BEEF_CAFE_F00D;
    bus.opdata2_i = 64'h0123_4567_89AB_CDEF;
    bus.signed1_i = 1'b1;
    wait_ready(e);
    n_checks++;
    if (bus.mul_res_o !== 64'd5000)
      $display("FAIL opchange got %h want 1388", bus.mul_res_o);
    else n_pass++;
    release_req();
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_basic_mul();
    test_signed_high();
    test_unsigned_mixed();
    test_mulw();
    test_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    test_operand_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iter_mul.md
Name: iter_mul

Overview:
- Iterative radix-2 shift-add multiplier for the RV64M MUL/MULH/MULHSU/MULHU/MULW group.
- Sits in the EX stage beside the iterative divider and uses the same start/annul/ready handshake, so EX stall logic treats both units identically.
- Takes operand magnitudes, accumulates a 2*XLEN-bit product over XLEN cycles (32 for word ops), sign-corrects, then holds the selected half until the requester drops start.

Parameters:
- XLEN, 64, operand width; only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  request; held high by the requester until it has consumed the result
- annul_i  in  1  flush; aborts an in-flight operation
- signed1_i  in  1  opdata1 is two's complement (MULH, MULHSU)
- signed2_i  in  1  opdata2 is two's complement (MULH)
- mul_32_i  in  1  MULW: uses low 32 bits of the operands; result is sign-extended low 32 bits of the product
- res_hi_i  in  1  select product[127:64] (MULH*); 0 selects product[63:0]; ignored when mul_32_i=1
- opdata1_i  in  64  multiplicand
- opdata2_i  in  64  multiplier
- mul_res_o  out  64  result; forced to 0 whenever ready_o=0
- ready_o  out  1  result valid (registered)

Behaviour:
- Reset: clk and rst are the clock and reset; reset is synchronous, active-high.
  - State=IDLE; ready_o=0; mul_res_o=0; product, counter and latched flags cleared.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - Accepts when start_i=1 and annul_i=0. Otherwise stays in IDLE with ready_o=0.
  - On accept, latch opdata1/2, signed1/2, mul_32, res_hi. Operand inputs may change afterwards without effect.
  - Magnitudes for the 64-bit path: |op| when the flag is set and bit 63=1, else the raw value. 0x8000_0000_0000_0000 yields unsigned 2^63, which is legal.
  - Result sign = (signed1 & op1[63]) XOR (signed2 & op2[63]).
  - mul_32: magnitudes are zero-extended op[31:0], signed flags ignored, sign=0.
  - Zero fast path: if either operand (as masked for mul_32) is 0, go directly to DONE with product=0. ready_o=1 after 1 edge.
  - Otherwise: BUSY, counter=0, 128-bit accumulator cleared.
- BUSY:
  - Each cycle: if multiplier bit[cnt]=1, add the multiplicand shifted by cnt into the accumulator (shift-register form is acceptable), then cnt+1.
  - Leaves for FIX after N cycles, N=64 (N=32 if mul_32).
- FIX (1 cycle): negate the 128-bit accumulator if sign=1, then go to DONE with ready_o=1.
  - Total latency from the accept edge to ready_o=1: N+2 edges, i.e. 66 for 64-bit ops, 34 for MULW.
- DONE:
  - ready_o=1 and mul_res_o valid. The result is constant while start_i stays high.
  - mul_32: {32{p[31]}, p[31:0]}. Otherwise res_hi ? p[127:64] : p[63:0].
  - When start_i=0: go to IDLE with ready_o=0 at that edge. A new request is accepted no earlier than the following cycle.
  - annul_i is ignored in DONE.
- Annul: annul_i=1 in BUSY or FIX → IDLE next edge; ready_o stays 0 and the partial result is discarded. In IDLE, annul_i blocks acceptance.
- Simultaneous start_i+annul_i in IDLE: not accepted.
- Reset mid-operation: returns to IDLE with ready_o=0 regardless of state.
- Arithmetic is modulo 2^128; no overflow flag.

Test Plan:
- Basic MUL: op1=7, op2=6, unsigned, res_hi=0 → ready_o after 66 edges, mul_res_o=0x2A. Drop start → ready_o=0 and mul_res_o=0 next cycle.
- Signed high words:
  - MULH (-1)*(-1) → 0x0.
  - MULH 0x8000_0000_0000_0000*(-1) → 0x0.
  - Same operands with res_hi=0 → 0x8000_0000_0000_0000.
- Unsigned and mixed high words:
  - MULHU 0xFFFF_FFFF_FFFF_FFFF squared → 0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU op1=-1 (signed), op2=2 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW: op1=0x1234_5678_7FFF_FFFF, op2=2 → ready_o after 34 edges, mul_res_o=0xFFFF_FFFF_FFFF_FFFE.
- Zero fast path and annul:
  - op2=0 → ready_o after 1 edge, result 0.
  - Separately, assert annul_i at BUSY cycle 10 → IDLE, ready_o never rises. A following request 3*5 completes correctly with 15.
- Reset and back-to-back:
  - rst pulse during BUSY → IDLE, ready_o=0.
  - Two back-to-back requests with start_i low for exactly one cycle between them → both results correct.
  - Changing opdata1_i during BUSY does not alter the result.
